// File: rtl/bitwise_arbiter.sv
// bitwise_arbiter
//   Two-requester round-robin front end for a shared combinational bitwise
//   unit. One operation is in flight at a time: IDLE (grant) -> EXEC (capture
//   result) -> RESP (hold until consumed).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid[1:0]           per-requester request valid
//   req_ready[1:0]           per-requester accept (one-hot in IDLE, else 0)
//   req_a0/req_b0/req_op0    requester 0 operands and op (00 AND,01 OR,10 XOR,11 XNOR)
//   req_a1/req_b1/req_op1    requester 1 operands and op
//   alu_a, alu_b             registered operands to the shared unit
//   alu_and/alu_or/alu_xor   combinational results from the shared unit
//   rsp_valid/rsp_ready      response handshake
//   rsp_data, rsp_id         result and owning requester
//   busy                     high whenever not IDLE
//   op_count                 completed responses, wraps at 2^CNT_W
module bitwise_arbiter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_and,
    input  logic [WIDTH-1:0] alu_or,
    input  logic [WIDTH-1:0] alu_xor,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             rr_q, rr_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [1:0]       op_q, op_d;
    logic             id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       gnt;
    logic             gnt_id;

    // Grant: favour the requester rr points at, fall back to the other one.
    // Gated by rst so req_ready reads 0 while reset is held even though the
    // registers already sit in IDLE.
    always_comb begin
        gnt = 2'b00;
        if (state_q == S_IDLE && !rst) begin
            if (req_valid[rr_q])       gnt[rr_q]  = 1'b1;
            else if (req_valid[~rr_q]) gnt[~rr_q] = 1'b1;
        end
    end

    assign gnt_id = gnt[1];

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        op_d        = op_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    alu_a_d = gnt_id ? req_a1  : req_a0;
                    alu_b_d = gnt_id ? req_b1  : req_b0;
                    op_d    = gnt_id ? req_op1 : req_op0;
                    id_d    = gnt_id;
                    rr_d    = ~gnt_id;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op_q)
                    2'b00:   rsp_data_d = alu_and;
                    2'b01:   rsp_data_d = alu_or;
                    2'b10:   rsp_data_d = alu_xor;
                    default: rsp_data_d = ~alu_xor;
                endcase
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rr_q        <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            op_q        <= 2'b00;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            cnt_q       <= cnt_d;
        end
    end

    assign req_ready = gnt;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = id_q;
    assign busy      = (state_q != S_IDLE);
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_bitwise_arbiter.sv
// Randomized + directed bench for bitwise_arbiter against a transaction-level
// reference model. CNT_W is shrunk to 2 so counter wrap shows up quickly.
module tb_bitwise_arbiter;

    localparam int W  = 4;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid, req_ready;
    logic [W-1:0]  req_a0, req_b0, req_a1, req_b1;
    logic [1:0]    req_op0, req_op1;
    logic [W-1:0]  alu_a, alu_b, alu_and, alu_or, alu_xor;
    logic          rsp_valid, rsp_ready, rsp_id, busy;
    logic [W-1:0]  rsp_data;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    // shared bitwise unit
    assign alu_and = alu_a & alu_b;
    assign alu_or  = alu_a | alu_b;
    assign alu_xor = alu_a ^ alu_b;

    bitwise_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1),
        .alu_a(alu_a), .alu_b(alu_b),
        .alu_and(alu_and), .alu_or(alu_or), .alu_xor(alu_xor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference model: phase 0 = free, 1 = operation accepted, 2 = answer pending
    int         m_phase;
    bit         m_next;
    logic [W-1:0] m_a, m_b, m_data;
    bit         m_id;
    int         m_cnt;
    bit         m_done;
    bit         saw_both;

    bit         rsp_ids[$];
    logic [W-1:0] rsp_datas[$];
    int         cnt_obs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result from per-bit counting of ones: AND needs two, OR at least one,
    // XOR exactly one, XNOR anything but one.
    function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) begin
            int ones;
            ones = int'(a[i]) + int'(b[i]);
            case (op)
                2'd0:    r[i] = (ones == 2);
                2'd1:    r[i] = (ones >= 1);
                2'd2:    r[i] = (ones == 1);
                default: r[i] = (ones != 1);
            endcase
        end
        return r;
    endfunction

    // Checks outputs for the current cycle (inputs already applied), then
    // advances the model across the coming edge and waits for the next negedge.
    task automatic step();
        logic [1:0] er;
        bit g;
        #1;
        er = 2'b00;
        if (m_phase == 0) begin
            if (req_valid[m_next])       er[m_next]  = 1'b1;
            else if (req_valid[!m_next]) er[!m_next] = 1'b1;
        end
        if (req_ready == 2'b11) saw_both = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("busy",      32'(busy),      32'(m_phase != 0));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
        chk("op_count",  32'(op_count),  32'(m_cnt));
        chk("alu_a",     32'(alu_a),     32'(m_a));
        chk("alu_b",     32'(alu_b),     32'(m_b));
        if (m_phase == 2) begin
            chk("rsp_data", 32'(rsp_data), 32'(m_data));
            chk("rsp_id",   32'(rsp_id),   32'(m_id));
        end
        if (m_done) begin
            cnt_obs.push_back(int'(op_count));
            m_done = 1'b0;
        end
        if (m_phase == 0) begin
            if (er != 2'b00) begin
                g       = er[1];
                m_a     = g ? req_a1 : req_a0;
                m_b     = g ? req_b1 : req_b0;
                m_data  = ref_op(m_a, m_b, g ? req_op1 : req_op0);
                m_id    = g;
                m_next  = !g;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else if (rsp_ready) begin
            rsp_ids.push_back(rsp_id);
            rsp_datas.push_back(rsp_data);
            m_phase = 0;
            m_cnt   = (m_cnt + 1) % (1 << CW);
            m_done  = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_id",    32'(rsp_id),    32'd0);
        chk("rst_alu_a",     32'(alu_a),     32'd0);
        chk("rst_alu_b",     32'(alu_b),     32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_op_count",  32'(op_count),  32'd0);
        m_phase = 0; m_next = 0; m_a = '0; m_b = '0; m_data = '0;
        m_id = 0; m_cnt = 0; m_done = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Steps until one more response completes; optionally drops the request
    // once it is accepted. One extra step captures the updated op_count.
    task automatic run_until_done(input int maxc, input bit keep);
        int k = 0;
        int n0 = rsp_ids.size();
        while (rsp_ids.size() == n0 && k < maxc) begin
            step();
            k++;
            if (!keep && m_phase != 0) req_valid = 2'b00;
        end
        if (k >= maxc) chk("timeout_done", 32'd1, 32'd0);
        step();
    endtask

    task automatic set_rq0(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        req_a0 = a; req_b0 = b; req_op0 = op;
    endtask

    initial begin
        logic [W-1:0] exp_ops [4];
        int exp_cnt [5];
        int k;
        exp_ops = '{4'b1000, 4'b1110, 4'b0110, 4'b1001};
        exp_cnt = '{1, 2, 3, 0, 1};

        req_valid = 2'b11; rsp_ready = 1'b1; saw_both = 1'b0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        req_op0 = '0; req_op1 = '0;
        @(negedge clk);
        do_reset();

        // single AND and the other three ops on requester 0
        for (int op = 0; op < 4; op++) begin
            set_rq0(4'b1100, 4'b1010, 2'(op));
            req_valid = 2'b01;
            rsp_ready = 1'b1;
            run_until_done(10, 1'b0);
            chk($sformatf("op%0d_data", op), 32'(rsp_datas[$]), 32'(exp_ops[op]));
            chk($sformatf("op%0d_id", op),   32'(rsp_ids[$]),   32'd0);
        end
        chk("and_count", 32'(cnt_obs[0]), 32'd1);

        // contention: both continuously valid, grants alternate from 0
        do_reset();
        req_a0 = 4'h3; req_b0 = 4'h5; req_a1 = 4'h9; req_b1 = 4'hC;
        req_op0 = 2'd2; req_op1 = 2'd1;
        req_valid = 2'b11; rsp_ready = 1'b1; saw_both = 1'b0;
        k = rsp_ids.size();
        for (int i = 0; i < 4; i++) run_until_done(10, 1'b1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("alt_id%0d", i), 32'(rsp_ids[k+i]), 32'(i % 2));
        chk("ready_both", 32'(saw_both), 32'd0);

        // backpressure: hold the response for 5 cycles
        req_valid = 2'b01; rsp_ready = 1'b0;
        k = 0;
        while (m_phase != 2 && k < 10) begin step(); k++; end
        if (k >= 10) chk("timeout_resp", 32'd1, 32'd0);
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) step();
        rsp_ready = 1'b1;
        run_until_done(10, 1'b1);

        // reset while in EXEC
        req_valid = 2'b01; rsp_ready = 1'b1;
        k = 0;
        while (m_phase != 0 && k < 10) begin req_valid = 2'b00; step(); k++; end
        req_valid = 2'b10;
        k = 0;
        while (m_phase != 1 && k < 10) begin step(); k++; end
        if (k >= 10) chk("timeout_exec", 32'd1, 32'd0);
        req_valid = 2'b11;
        do_reset();
        req_valid = 2'b00;
        for (int i = 0; i < 3; i++) step();
        req_valid = 2'b11;
        run_until_done(10, 1'b1);
        chk("post_rst_id", 32'(rsp_ids[$]), 32'd0);

        // counter wrap with CNT_W=2
        do_reset();
        cnt_obs.delete();
        for (int i = 0; i < 5; i++) begin
            req_a1 = W'($urandom); req_b1 = W'($urandom); req_op1 = 2'($urandom);
            req_valid = 2'b10;
            run_until_done(10, 1'b0);
        end
        for (int i = 0; i < 5; i++)
            chk($sformatf("wrap%0d", i), 32'(cnt_obs[i]), 32'(exp_cnt[i]));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            req_valid = 2'($urandom);
            req_a0 = W'($urandom); req_b0 = W'($urandom); req_op0 = 2'($urandom);
            req_a1 = W'($urandom); req_b1 = W'($urandom); req_op1 = 2'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
